// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : Drives the shared iterative mult/div unit for the execute
//               stage. Accepts one request at a time, issues a one-cycle
//               ctrl_MULT/ctrl_DIV start pulse with registered operands,
//               stalls the pipeline until md_resultRDY or a timeout, then
//               returns result/tag/exception/status with a done pulse.
// Ports       : clock, reset (sync, active-high)
//               req_*      : request from execute stage
//               md_*       : operands to / result from the mult/div unit
//               ctrl_MULT, ctrl_DIV : start pulses
//               stall, busy, done   : pipeline control / status
//               result, result_tag, exception, status_code : captured outcome
//               timeout_err         : sticky timeout fault
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer #(
    parameter int unsigned TIMEOUT  = 40,
    parameter logic [4:0]  CODE_MUL = 5'd4,
    parameter logic [4:0]  CODE_DIV = 5'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_is_div,
    input  logic [4:0]  req_tag,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  result_tag,
    output logic        exception,
    output logic [31:0] status_code,
    output logic        timeout_err
);

    localparam int unsigned          c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_LAUNCH = 2'd1;
    localparam logic [1:0] c_S_WAIT   = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_md_a;
    logic [31:0]        r_md_b;
    logic               r_is_div;
    logic [4:0]         r_tag;
    logic [31:0]        r_result;
    logic [4:0]         r_result_tag;
    logic               r_exception;
    logic [31:0]        r_status;
    logic               r_timeout_err;
    logic               w_cnt_last;
    logic [4:0]         w_code;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_code     = r_is_div ? CODE_DIV : CODE_MUL;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (req_valid) w_next_state = c_S_LAUNCH;
            c_S_LAUNCH: w_next_state = c_S_WAIT;
            // RDY and timeout both lead to DONE; which one wins only matters
            // for the captured values in the datapath below.
            c_S_WAIT:   if (md_resultRDY || w_cnt_last) w_next_state = c_S_DONE;
            c_S_DONE:   w_next_state = c_S_IDLE;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        stall     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                // Stall in the very cycle the request appears so the
                // instruction stays in execute while the unit runs.
                stall = req_valid;
                busy  = 1'b0;
            end
            c_S_LAUNCH: begin
                stall     = 1'b1;
                ctrl_DIV  = r_is_div;
                ctrl_MULT = ~r_is_div;
            end
            c_S_WAIT: begin
                stall = 1'b1;
            end
            c_S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, cycle counter, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= '0;
            r_md_a        <= '0;
            r_md_b        <= '0;
            r_is_div      <= 1'b0;
            r_tag         <= '0;
            r_result      <= '0;
            r_result_tag  <= '0;
            r_exception   <= 1'b0;
            r_status      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (req_valid) begin
                        r_md_a   <= operand_a;
                        r_md_b   <= operand_b;
                        r_is_div <= req_is_div;
                        r_tag    <= req_tag;
                    end
                end
                c_S_LAUNCH: begin
                    r_cnt <= '0;
                end
                c_S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (md_resultRDY) begin
                        r_result     <= md_exception ? 32'd0 : md_result;
                        r_exception  <= md_exception;
                        r_status     <= md_exception ? {27'd0, w_code} : 32'd0;
                        r_result_tag <= r_tag;
                    end else if (w_cnt_last) begin
                        r_result      <= 32'd0;
                        r_exception   <= 1'b1;
                        r_status      <= {27'd0, w_code};
                        r_result_tag  <= r_tag;
                        r_timeout_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign md_operand_a = r_md_a;
    assign md_operand_b = r_md_b;
    assign result       = r_result;
    assign result_tag   = r_result_tag;
    assign exception    = r_exception;
    assign status_code  = r_status;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Sequences the shared iterative mult/div unit on behalf of the execute stage of the 5-stage pipeline. It accepts one mult/div request at a time and issues a single-cycle ctrl_MULT or ctrl_DIV start pulse with registered operands. It holds the pipeline stall until the result is ready, or until a timeout expires. It then returns the result, destination tag and rstatus exception code, with a one-cycle done pulse.

Parameters:
TIMEOUT, 40, WAIT-state cycles allowed before a missing resultRDY is declared a fault
CODE_MUL, 4, rstatus value written on a mult exception
CODE_DIV, 5, rstatus value written on a div exception

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  execute stage holds a mult/div instruction
req_is_div  input  1  1 = div, 0 = mult
req_tag  input  5  destination register of the request
operand_a  input  32  rs value
operand_b  input  32  rt value
md_operand_a  output  32  registered operand A to the unit
md_operand_b  output  32  registered operand B to the unit
ctrl_MULT  output  1  one-cycle mult start pulse
ctrl_DIV  output  1  one-cycle div start pulse
md_result  input  32  unit result
md_exception  input  1  unit exception (overflow / divide by zero)
md_resultRDY  input  1  unit result valid
stall  output  1  freezes the PC and all pipeline latches
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
result  output  32  captured result; 0 when exception=1
result_tag  output  5  captured destination register
exception  output  1  captured exception flag
status_code  output  32  CODE_MUL/CODE_DIV when exception=1, else 0
timeout_err  output  1  sticky timeout fault flag

Behaviour:
- Reset:
  - state goes to IDLE.
  - All registered outputs clear to 0, including timeout_err and the cycle counter.
  - The unit itself is not reset by this block. Any md_resultRDY seen after reset while in IDLE is ignored.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - When req_valid=1:
    - capture operand_a/b into md_operand_a/b;
    - capture req_is_div and req_tag;
    - go to LAUNCH.
- LAUNCH:
  - stall=1.
  - ctrl_DIV=1 if the request is div, else ctrl_MULT=1. The pulse lasts exactly this cycle.
  - Counter clears to 0. Go to WAIT.
  - md_resultRDY and req_valid are ignored.
- WAIT:
  - stall=1; counter increments every cycle.
  - If md_resultRDY=1: capture md_result, md_exception and status code, then go to DONE.
  - Else if counter == TIMEOUT-1:
    - exception=1, result=0;
    - status_code = CODE_DIV or CODE_MUL;
    - timeout_err=1;
    - go to DONE.
  - RDY and timeout firing in the same cycle: RDY wins.
- DONE:
  - done=1 and stall=0, so the pipeline latches advance at the end of this cycle. Go to IDLE.
  - req_valid is ignored in DONE. It still reflects the completed instruction.
- Output holding:
  - result, result_tag, exception and status_code are registered.
  - They are valid from DONE onward and held until the next capture.
  - status_code = {27'd0, code} on exception, else 0.
- Timing: request seen in IDLE at cycle 0, pulse at cycle 1, RDY first sampled at cycle 2.
  - If RDY is sampled at cycle k, then done is at cycle k+1.
  - stall is high for cycles 0..k.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately after DONE. Exactly one start pulse is issued per instruction.
- Widths: all arithmetic is done by the unit. The counter is wide enough to hold TIMEOUT-1.
- timeout_err is cleared only by reset.

Test Plan:
1. Mult 7×6, tag 5; model raises RDY 17 cycles after the pulse -> ctrl_MULT high only in cycle 1; stall high cycles 0..18; done in cycle 19; result=42, result_tag=5, exception=0, status_code=0.
2. Div 100÷0; model returns md_exception=1 -> done with exception=1, result=0, status_code=5; ctrl_MULT never pulses.
3. Mult 3×4 then immediately div 20÷4 -> second request accepted in the IDLE cycle after the first done; exactly one ctrl_MULT and one ctrl_DIV pulse; results 12 then 5, each with its own tag.
4. Mult with RDY never asserted, TIMEOUT=40 -> done 41 cycles after the pulse; exception=1, status_code=4, timeout_err=1; timeout_err still 1 after a subsequent normal op.
5. Reset asserted mid-WAIT -> next cycle stall=0, busy=0, all outputs 0; a late RDY is ignored; a new mult 2×2 completes with result 4.
6. Spurious RDY held high during LAUNCH only -> ignored; sequencer waits for the genuine RDY in WAIT.
